cordic_vector_pipe: RTL

//   Parametrised, fully pipelined CORDIC vectoring engine: converts signed (ix,iy) to magnitude and

---
 rtl/cordic_vector_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_vector_pipe.sv
// cordic_vector_pipe: fully pipelined CORDIC vectoring, signed (ix,iy) -> magnitude and 0..360 deg angle.
// All registers, including the valid chain, advance only when ien is high; optional K-compensation stage.
module cordic_vector_pipe #(
    parameter int W         = 16,
    parameter int ITER      = 12,
    parameter int ANG_FRAC  = 6,
    parameter int GAIN_COMP = 1
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                ien,
    input  logic                ivalid,
    input  logic [W-1:0]        ix,
    input  logic [W-1:0]        iy,
    output logic                ovalid,
    output logic [W:0]          omag,
    output logic [8+ANG_FRAC:0] oang
);
    localparam int DW  = W + 2;
    localparam int ZW  = ANG_FRAC + 11;
    localparam int AW  = ANG_FRAC + 9;
    localparam int RSH = 16 - ANG_FRAC;
    localparam logic [31:0] RND = (32'd1 << RSH) >> 1;
    localparam logic signed [ZW-1:0] DEG90  = ZW'(90 * (2 ** ANG_FRAC));
    localparam logic signed [ZW-1:0] DEG180 = ZW'(180 * (2 ** ANG_FRAC));
    localparam logic signed [ZW-1:0] DEG270 = ZW'(270 * (2 ** ANG_FRAC));
    localparam logic signed [ZW-1:0] DEG360 = ZW'(360 * (2 ** ANG_FRAC));

    // atan(2^-i) in degrees, Q.16
    function automatic logic [31:0] atan_q16(input int unsigned i);
        case (i)
            0:       atan_q16 = 32'd2949120;
            1:       atan_q16 = 32'd1740967;
            2:       atan_q16 = 32'd919879;
            3:       atan_q16 = 32'd466945;
            4:       atan_q16 = 32'd234379;
            5:       atan_q16 = 32'd117304;
            6:       atan_q16 = 32'd58666;
            7:       atan_q16 = 32'd29335;
            8:       atan_q16 = 32'd14668;
            9:       atan_q16 = 32'd7334;
            10:      atan_q16 = 32'd3667;
            11:      atan_q16 = 32'd1833;
            12:      atan_q16 = 32'd917;
            13:      atan_q16 = 32'd458;
            14:      atan_q16 = 32'd229;
            15:      atan_q16 = 32'd115;
            default: atan_q16 = 32'd0;
        endcase
    endfunction

    function automatic logic signed [ZW-1:0] atan_step(input int unsigned i);
        return ZW'((atan_q16(i) + RND) >> RSH);
    endfunction

    logic signed [DW-1:0] xs [0:ITER];
    logic signed [DW-1:0] ys [0:ITER];
    logic signed [ZW-1:0] zs [0:ITER];
    logic [1:0]           quad [0:ITER];
    logic [ITER:0]        vld, flip, zero, axis;

    logic signed [DW-1:0] sx, sy;
    logic [1:0]           quad_in;
    logic                 axis_in;

    // Pure-axis inputs bypass the CORDIC angle so they land exactly on 0/90/180/270
    always_comb begin
        sx      = {{2{ix[W-1]}}, ix};
        sy      = {{2{iy[W-1]}}, iy};
        axis_in = (ix == '0) != (iy == '0);
        if (iy == '0) quad_in = ix[W-1] ? 2'd2 : 2'd0;
        else          quad_in = iy[W-1] ? 2'd3 : 2'd1;
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            for (int unsigned k = 0; k <= ITER; k++) begin
                xs[k]   <= '0;
                ys[k]   <= '0;
                zs[k]   <= '0;
                quad[k] <= '0;
            end
            vld  <= '0;
            flip <= '0;
            zero <= '0;
            axis <= '0;
        end else if (ien) begin
            xs[0]   <= ix[W-1] ? -sx : sx;
            ys[0]   <= ix[W-1] ? -sy : sy;
            zs[0]   <= '0;
            quad[0] <= quad_in;
            vld[0]  <= ivalid;
            flip[0] <= ix[W-1];
            zero[0] <= (ix == '0) && (iy == '0);
            axis[0] <= axis_in;
            for (int unsigned k = 0; k < ITER; k++) begin
                if (!ys[k][DW-1]) begin
                    xs[k+1] <= xs[k] + (ys[k] >>> k);
                    ys[k+1] <= ys[k] - (xs[k] >>> k);
                    zs[k+1] <= zs[k] + atan_step(k);
                end else begin
                    xs[k+1] <= xs[k] - (ys[k] >>> k);
                    ys[k+1] <= ys[k] + (xs[k] >>> k);
                    zs[k+1] <= zs[k] - atan_step(k);
                end
                quad[k+1] <= quad[k];
                vld[k+1]  <= vld[k];
                flip[k+1] <= flip[k];
                zero[k+1] <= zero[k];
                axis[k+1] <= axis[k];
            end
        end
    end

    logic signed [ZW-1:0] a_sum, a_wrap;
    logic [AW-1:0]        ang_n;
    logic [DW-1:0]        x_n;

    always_comb begin
        a_sum  = zs[ITER] + (flip[ITER] ? DEG180 : '0);
        a_wrap = a_sum[ZW-1] ? a_sum + DEG360 : a_sum;
        if (zero[ITER]) begin
            ang_n = '0;
        end else if (axis[ITER]) begin
            case (quad[ITER])
                2'd0:    ang_n = '0;
                2'd1:    ang_n = AW'(DEG90);
                2'd2:    ang_n = AW'(DEG180);
                default: ang_n = AW'(DEG270);
            endcase
        end else begin
            ang_n = AW'(a_wrap);
        end
        x_n = (zero[ITER] || xs[ITER][DW-1]) ? '0 : xs[ITER];
    end

    if (GAIN_COMP != 0) begin : g_gain
        logic [AW-1:0]  ang_s;
        logic [DW-1:0]  x_s;
        logic           vld_s;
        logic [DW+15:0] prod;
        logic [DW-1:0]  scaled;
        logic [W:0]     mag_n;
        logic           unused_lsb;

        always_comb begin
            prod   = (DW+16)'(x_s) * (DW+16)'(16'h9B75) + (DW+16)'(32'h8000);
            scaled = prod[DW+15:16];
            mag_n  = (|scaled[DW-1:W+1]) ? '1 : scaled[W:0];
        end
        assign unused_lsb = ^prod[15:0];

        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                ang_s  <= '0;
                x_s    <= '0;
                vld_s  <= 1'b0;
                ovalid <= 1'b0;
                oang   <= '0;
                omag   <= '0;
            end else if (ien) begin
                ang_s  <= ang_n;
                x_s    <= x_n;
                vld_s  <= vld[ITER];
                ovalid <= vld_s;
                oang   <= ang_s;
                omag   <= mag_n;
            end
        end
    end else begin : g_raw
        logic unused_hi;
        assign unused_hi = ^x_n[DW-1:W+1];

        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                ovalid <= 1'b0;
                oang   <= '0;
                omag   <= '0;
            end else if (ien) begin
                ovalid <= vld[ITER];
                oang   <= ang_n;
                omag   <= x_n[W:0];
            end
        end
    end
endmodule
